// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of an asynchronous PWM input
// in clk cycles. It reports one result per complete PWM cycle and flags a PWM
// that has stopped producing rising edges.
module pwm_capture #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             valid_o,
   output logic             stuck_o,
   output logic             level_o
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] high_cap_q, high_cap_d;
   logic [CNT_W-1:0] period_d, high_d;
   logic             valid_d, stuck_d, level_d;
   logic             rise, fall, cnt_sat;

   // Edges are taken between the synchronised level and its one-cycle delay.
   assign rise    = s2_q & ~s3_q;
   assign fall    = ~s2_q & s3_q;
   assign cnt_sat = (cnt_q == TIMEOUT_C);

   // Next-state and result logic; rise takes priority over the timeout.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_sat ? cnt_q : cnt_q + ONE_C;
      high_cap_d = high_cap_q;
      period_d   = period_o;
      high_d     = high_o;
      valid_d    = 1'b0;
      stuck_d    = stuck_o;
      level_d    = level_o;
      case (state_q)
         IDLE: begin
            // First rise only starts a measurement; that period is incomplete.
            if (rise) begin
               state_d = MEASURE;
               cnt_d   = ONE_C;
            end
         end
         MEASURE: begin
            if (fall) high_cap_d = cnt_q;
            if (rise) begin
               period_d = cnt_q;
               high_d   = high_cap_q;
               valid_d  = 1'b1;
               stuck_d  = 1'b0;
               cnt_d    = ONE_C;
            end else if (cnt_sat) begin
               stuck_d = 1'b1;
               level_d = s2_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Synchroniser, edge-detect delay and all measurement/result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         cnt_q      <= '0;
         high_cap_q <= '0;
         period_o   <= '0;
         high_o     <= '0;
         valid_o    <= 1'b0;
         stuck_o    <= 1'b0;
         level_o    <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= pwm_i;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         cnt_q      <= cnt_d;
         high_cap_q <= high_cap_d;
         period_o   <= period_d;
         high_o     <= high_d;
         valid_o    <= valid_d;
         stuck_o    <= stuck_d;
         level_o    <= level_d;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: scoreboard of expected {period, high} pairs pushed as
// each completing rise is driven, popped when valid_o pulses.
module tb_pwm_capture;

   localparam int CNT_W = 32;
   localparam int TO    = 1000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pwm_i = 1'b0;
   logic [CNT_W-1:0] period_o, high_o;
   logic             valid_o, stuck_o, level_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] sb[$];
   bit armed = 0;
   int last_p = 0, last_h = 0;

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .pwm_i(pwm_i),
      .period_o(period_o), .high_o(high_o),
      .valid_o(valid_o), .stuck_o(stuck_o), .level_o(level_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period"}, 64'(period_o), 0);
      chk({tag, "_high"}, 64'(high_o), 0);
      chk({tag, "_flags"}, 64'({valid_o, stuck_o, level_o}), 0);
   endtask

   // One PWM cycle starting with a rise; that rise completes the previous one.
   task automatic pwm_cycle(input int p, input int h);
      pwm_i = 1'b1;
      if (armed) sb.push_back({32'(last_p), 32'(last_h)});
      armed  = 1;
      last_p = p;
      last_h = h;
      repeat (h) tick();
      pwm_i = 1'b0;
      repeat (p - h) tick();
   endtask

   // Compare every result against the scoreboard.
   always @(negedge clk) begin
      if (valid_o) begin
         if (sb.size() == 0) chk("spurious_valid", 64'(valid_o), 0);
         else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("period", 64'(period_o), 64'(e[63:32]));
            chk("high", 64'(high_o), 64'(e[31:0]));
            chk("stuck_on_valid", 64'(stuck_o), 0);
         end
      end
   end

   initial begin
      // 1: reset with a toggling input
      #1;
      for (int i = 0; i < 5; i++) begin
         pwm_i = i[0];
         tick();
         chk_zero("reset");
      end
      pwm_i = 1'b0;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk_zero("post_reset");

      // 2: steady P=100 H=25, first rise gives no result
      repeat (9) pwm_cycle(100, 25);
      chk("steady_drained", 64'(sb.size()), 0);

      // 3: frequency switch mid-period, then narrowest guaranteed pulses
      repeat (3) pwm_cycle(100, 50);
      pwm_cycle(70, 50);
      repeat (4) pwm_cycle(40, 10);
      repeat (4) pwm_cycle(4, 2);
      pwm_cycle(100, 25);
      chk("switch_drained", 64'(sb.size()), 0);

      // Period equal to TIMEOUT: rise wins, no stuck
      repeat (2) pwm_cycle(TO, 500);
      pwm_cycle(100, 25);
      chk("to_boundary_drained", 64'(sb.size()), 0);
      chk("to_boundary_stuck", 64'(stuck_o), 0);

      // 4: stuck high
      pwm_i = 1'b1;
      if (armed) sb.push_back({32'(last_p), 32'(last_h)});
      repeat (995) tick();
      chk("stuck_hi_early", 64'(stuck_o), 0);
      repeat (15) tick();
      armed = 0;
      chk("stuck_hi", 64'(stuck_o), 1);
      chk("stuck_hi_level", 64'(level_o), 1);
      chk("stuck_hi_period_hold", 64'(period_o), 100);
      pwm_i = 1'b0;
      repeat (30) tick();
      pwm_cycle(100, 25);
      chk("stuck_hi_sticky", 64'(stuck_o), 1);
      repeat (2) pwm_cycle(100, 25);
      chk("stuck_hi_cleared", 64'(stuck_o), 0);
      chk("stuck_hi_drained", 64'(sb.size()), 0);

      // 5: stuck low, results hold
      repeat (1100) tick();
      armed = 0;
      chk("stuck_lo", 64'(stuck_o), 1);
      chk("stuck_lo_level", 64'(level_o), 0);
      chk("stuck_lo_period_hold", 64'(period_o), 100);
      chk("stuck_lo_high_hold", 64'(high_o), 25);

      // 6: reset 30 cycles into a period
      repeat (3) pwm_cycle(100, 25);
      pwm_i = 1'b1;
      sb.push_back({32'(last_p), 32'(last_h)});
      repeat (25) tick();
      pwm_i = 1'b0;
      repeat (5) tick();
      chk("pre_rst_drained", 64'(sb.size()), 0);
      rst = 1'b1;
      repeat (5) tick();
      chk_zero("mid_reset");
      rst = 1'b0;
      armed = 0;
      repeat (10) tick();
      repeat (3) pwm_cycle(100, 25);
      chk("final_drained", 64'(sb.size()), 0);
      chk("final_period", 64'(period_o), 100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
